// File: rtl/mul_wtsk.sv
// Unsigned 4x4 Wallace-tree multiplier with a registered product copy.
// Partial products are reduced in two carry-save stages down to two rows,
// then summed by a ripple-carry adder whose carry-out is the product MSB.

// Half adder: two bits in, sum and carry out.
module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic carry_o
);

    // Sum and carry of two equally weighted bits
    always_comb begin
        sum_o   = a_i ^ b_i;
        carry_o = a_i & b_i;
    end

endmodule

// Full adder: three bits in, sum and carry out.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic sum_o,
    output logic carry_o
);

    // Sum and majority carry of three equally weighted bits
    always_comb begin
        sum_o   = a_i ^ b_i ^ c_i;
        carry_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    end

endmodule

// Top level: combinational product S and its registered copy S_q.
module mul_wtsk (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [7:0] S,
    output logic [7:0] S_q
);

    // pp[i][j] = A[j] & B[i], weight 2^(i+j)
    logic [3:0] pp [4];

    // Stage 1 (column 3 height 4 -> 3, column 4 kept at 3)
    logic s1_3, c1_3;
    logic s1_4, c1_4;

    // Stage 2 (columns 2..5 each reduced to at most two rows)
    logic s2_2, c2_2;
    logic s2_3, c2_3;
    logic s2_4, c2_4;
    logic s2_5, c2_5;

    // Ripple carries between final-adder columns
    logic k1, k2, k3, k4, k5;

    logic [7:0] prod;
    logic [7:0] prod_d;
    logic [7:0] prod_q;

    // Partial-product AND array
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                pp[i][j] = A[j] & B[i];
            end
        end
    end

    // Stage 1: trim column 3 and pre-reduce column 4 so every column fits one full adder
    half_adder u_h1_3 (
        .a_i     (pp[0][3]),
        .b_i     (pp[1][2]),
        .sum_o   (s1_3),
        .carry_o (c1_3)
    );
    half_adder u_h1_4 (
        .a_i     (pp[1][3]),
        .b_i     (pp[2][2]),
        .sum_o   (s1_4),
        .carry_o (c1_4)
    );

    // Stage 2: one full adder per three-high column leaves exactly two rows
    full_adder u_f2_2 (
        .a_i     (pp[0][2]),
        .b_i     (pp[1][1]),
        .c_i     (pp[2][0]),
        .sum_o   (s2_2),
        .carry_o (c2_2)
    );
    full_adder u_f2_3 (
        .a_i     (pp[2][1]),
        .b_i     (pp[3][0]),
        .c_i     (s1_3),
        .sum_o   (s2_3),
        .carry_o (c2_3)
    );
    full_adder u_f2_4 (
        .a_i     (pp[3][1]),
        .b_i     (c1_3),
        .c_i     (s1_4),
        .sum_o   (s2_4),
        .carry_o (c2_4)
    );
    full_adder u_f2_5 (
        .a_i     (pp[2][3]),
        .b_i     (pp[3][2]),
        .c_i     (c1_4),
        .sum_o   (s2_5),
        .carry_o (c2_5)
    );

    // Final carry-propagate adder, columns 1..6; carry-out of column 6 is bit 7
    half_adder u_r1 (
        .a_i     (pp[0][1]),
        .b_i     (pp[1][0]),
        .sum_o   (prod[1]),
        .carry_o (k1)
    );
    half_adder u_r2 (
        .a_i     (s2_2),
        .b_i     (k1),
        .sum_o   (prod[2]),
        .carry_o (k2)
    );
    full_adder u_r3 (
        .a_i     (s2_3),
        .b_i     (c2_2),
        .c_i     (k2),
        .sum_o   (prod[3]),
        .carry_o (k3)
    );
    full_adder u_r4 (
        .a_i     (s2_4),
        .b_i     (c2_3),
        .c_i     (k3),
        .sum_o   (prod[4]),
        .carry_o (k4)
    );
    full_adder u_r5 (
        .a_i     (s2_5),
        .b_i     (c2_4),
        .c_i     (k4),
        .sum_o   (prod[5]),
        .carry_o (k5)
    );
    full_adder u_r6 (
        .a_i     (pp[3][3]),
        .b_i     (c2_5),
        .c_i     (k5),
        .sum_o   (prod[6]),
        .carry_o (prod[7])
    );

    // Column 0 is a single partial product; next-state of the product register
    always_comb begin
        prod[0] = pp[0][0];
        prod_d  = prod;
        S       = prod;
        S_q     = prod_q;
    end

    // Product register, cleared asynchronously by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q <= 8'h00;
        end else begin
            prod_q <= prod_d;
        end
    end

endmodule

// File: tb/tb_mul_wtsk.sv
// Self-checking bench for mul_wtsk: directed vector table, exhaustive sweep,
// and hand-written register / asynchronous reset sequences.
module tb_mul_wtsk;

    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic [7:0] S;
    logic [7:0] S_q;

    int n_tests;
    int n_failed;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp_s;
    } vec_t;

    vec_t vecs [7];

    mul_wtsk dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .S   (S),
        .S_q (S_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [7:0] exp_p;
        n_tests  = 0;
        n_failed = 0;

        vecs[0] = '{a: 4'd0,  b: 4'd9,  exp_s: 8'h00};
        vecs[1] = '{a: 4'd1,  b: 4'd13, exp_s: 8'h0D};
        vecs[2] = '{a: 4'd15, b: 4'd15, exp_s: 8'hE1};
        vecs[3] = '{a: 4'd8,  b: 4'd8,  exp_s: 8'h40};
        vecs[4] = '{a: 4'd15, b: 4'd1,  exp_s: 8'h0F};
        vecs[5] = '{a: 4'd15, b: 4'd2,  exp_s: 8'h1E};
        vecs[6] = '{a: 4'd12, b: 4'd14, exp_s: 8'hA8};

        // Reset state: S_q held at zero across clock edges while rst is high
        rst = 1'b1;
        A   = 4'd15;
        B   = 4'd15;
        #2;
        check("reset_sq", S_q, 8'h00);
        check("reset_s_comb", S, 8'hE1);
        repeat (2) @(posedge clk);
        #1;
        check("reset_sq_held", S_q, 8'h00);

        @(negedge clk);
        rst = 1'b0;

        // Directed table: combinational S then registered S_q
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            A = vecs[i].a;
            B = vecs[i].b;
            #1;
            check($sformatf("vec%0d_s", i), S, vecs[i].exp_s);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_sq", i), S_q, vecs[i].exp_s);
        end

        // Exhaustive sweep of all operand pairs
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                A = a[3:0];
                B = b[3:0];
                #10;
                exp_p = 8'(a * b);
                check($sformatf("exh_%0dx%0d", a, b), S, exp_p);
            end
        end

        // Register: holds old value until the next rising edge
        @(negedge clk);
        A = 4'd7;
        B = 4'd6;
        @(posedge clk);
        #1;
        check("reg_7x6", S_q, 8'h2A);
        @(negedge clk);
        A = 4'd3;
        B = 4'd5;
        #1;
        check("reg_hold", S_q, 8'h2A);
        check("reg_new_s", S, 8'h0F);
        @(posedge clk);
        #1;
        check("reg_3x5", S_q, 8'h0F);

        // Asynchronous reset between edges
        @(negedge clk);
        A = 4'd15;
        B = 4'd15;
        @(posedge clk);
        #1;
        check("pre_rst_sq", S_q, 8'hE1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_sq", S_q, 8'h00);
        check("async_rst_s", S, 8'hE1);

        // Release: reload on first rising edge after deassertion
        A = 4'd9;
        B = 4'd9;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("release_no_edge", S_q, 8'h00);
        @(posedge clk);
        #1;
        check("release_9x9", S_q, 8'h51);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
